// File: rtl/my_adder_pkg.sv
// Shared definitions for the my_adder arithmetic engine and its register slave:
// opcode encoding, result record and default widths.
package my_adder_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  carry;
    logic                  ovf;
  } res_t;

endpackage

// File: rtl/my_adder_if.sv
// Command/result handshake bundle between the register slave (master side)
// and the arithmetic core (slave side).
interface my_adder_if
  import my_adder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_ovf
  );

endinterface

// File: rtl/my_adder_res_fifo.sv
// In-order first-word-fall-through result FIFO. The head entry is visible
// whenever the FIFO is non-empty; pushes while full and pops while empty are
// ignored. Storage is cleared by reset so the head reads zero afterwards.
module my_adder_res_fifo
  import my_adder_pkg::*;
#(
  parameter type entry_t = res_t,
  parameter int  DEPTH   = FIFO_DEPTH_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  entry_t  push_data,
  input  logic    pop,
  output entry_t  head,
  output logic [CW-1:0] count,
  output logic    full,
  output logic    empty
);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_s, empty_s;
  logic            push_ok_s, pop_ok_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // Next-state for storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_comb begin
    push_ok_s = push && !full_s;
    pop_ok_s  = pop && !empty_s;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/my_adder_core.sv
// my_adder_core: arithmetic engine behind the my_adder register slave.
// Commands (ADD/SUB/ACC/CLR) are computed into stage S1 at acceptance, then
// moved into an in-order FWFT result FIFO on the following edge.
// Optional build macro: MY_ADDER_SAT_EN -- clamp results to the signed
// extremes on overflow (acc keeps the clamped value). Undefined: wrap.
module my_adder_core
  import my_adder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  my_adder_if.slave   bus,
  output logic [31:0] op_count,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] OUT_LIMIT = (CW + 1)'(FIFO_DEPTH);

`ifdef MY_ADDER_SAT_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              ovf;
  } entry_t;

  // Arithmetic datapath
  logic [DATA_W-1:0] op_x_s, op_y_s;
  logic [DATA_W:0]   sum_s, diff_s;
  entry_t            calc_s;

  // Pipeline / control state
  logic              s1_valid_q, s1_valid_d;
  entry_t            s1_res_q, s1_res_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [31:0]       op_count_q, op_count_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;

  logic              accept_s, push_s, pop_ok_s;
  logic [CW-1:0]     fifo_count_s, fifo_count_nxt_s;
  logic [CW:0]       outstanding_s;
  logic              fifo_full_s, fifo_empty_s;
  entry_t            head_s;

  // Select operands and compute result, carry/borrow and signed overflow.
  always_comb begin
    if (bus.cmd_op == OP_ACC) begin
      op_x_s = acc_q;
      op_y_s = bus.cmd_a;
    end else begin
      op_x_s = bus.cmd_a;
      op_y_s = bus.cmd_b;
    end
    sum_s  = {1'b0, op_x_s} + {1'b0, op_y_s};
    diff_s = {1'b0, op_x_s} - {1'b0, op_y_s};
    calc_s = '0;
    case (bus.cmd_op)
      OP_ADD, OP_ACC: begin
        calc_s.data  = sum_s[DATA_W-1:0];
        calc_s.carry = sum_s[DATA_W];
        calc_s.ovf   = (op_x_s[DATA_W-1] == op_y_s[DATA_W-1]) &&
                       (sum_s[DATA_W-1] != op_x_s[DATA_W-1]);
      end
      OP_SUB: begin
        // MSB of the zero-extended difference is the unsigned borrow (a < b).
        calc_s.data  = diff_s[DATA_W-1:0];
        calc_s.carry = diff_s[DATA_W];
        calc_s.ovf   = (op_x_s[DATA_W-1] != op_y_s[DATA_W-1]) &&
                       (diff_s[DATA_W-1] != op_x_s[DATA_W-1]);
      end
      OP_CLR: begin
        calc_s = '0;
      end
      default: begin
        calc_s = '0;
      end
    endcase
`ifdef MY_ADDER_SAT_EN
    // Overflow direction always matches the sign of the first operand.
    if (calc_s.ovf) begin
      calc_s.data = op_x_s[DATA_W-1] ? MIN_NEG : MAX_POS;
    end else begin
      calc_s.data = calc_s.data;
    end
`endif
  end

  assign accept_s = bus.cmd_valid && cmd_ready_q;
  // Ready accounting guarantees room; gating on full only guards the FIFO.
  assign push_s   = s1_valid_q && !fifo_full_s;
  assign pop_ok_s = bus.res_ready && !fifo_empty_s;

  // Next-state for S1, accumulator, command counter, ready and busy.
  always_comb begin
    s1_valid_d = accept_s;
    if (accept_s) begin
      s1_res_d   = calc_s;
      op_count_d = op_count_q + 32'd1;
      case (bus.cmd_op)
        OP_ACC:  acc_d = calc_s.data;
        OP_CLR:  acc_d = {DATA_W{1'b0}};
        default: acc_d = acc_q;
      endcase
    end else begin
      s1_res_d   = s1_res_q;
      op_count_d = op_count_q;
      acc_d      = acc_q;
    end
    case ({push_s, pop_ok_s})
      2'b10:   fifo_count_nxt_s = fifo_count_s + CW'(1'b1);
      2'b01:   fifo_count_nxt_s = fifo_count_s - CW'(1'b1);
      default: fifo_count_nxt_s = fifo_count_s;
    endcase
    // Outstanding results (FIFO plus S1) after this edge must stay below depth.
    outstanding_s = {1'b0, fifo_count_nxt_s} + {{CW{1'b0}}, s1_valid_d};
    cmd_ready_d   = (outstanding_s < OUT_LIMIT);
    busy_d        = s1_valid_d || (fifo_count_nxt_s != {CW{1'b0}});
  end

  // Core state registers; reset discards all in-flight work immediately.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid_q  <= 1'b0;
      s1_res_q    <= '0;
      acc_q       <= '0;
      op_count_q  <= 32'd0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_res_q    <= s1_res_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  my_adder_res_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (push_s),
    .push_data (s1_res_q),
    .pop       (bus.res_ready),
    .head      (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = !fifo_empty_s;
  assign bus.res_data  = head_s.data;
  assign bus.res_carry = head_s.carry;
  assign bus.res_ovf   = head_s.ovf;
  assign op_count      = op_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_my_adder_core.sv
// Directed + randomized bench for my_adder_core with a queue-based reference
// model of the S1 stage, result FIFO, accumulator and command counter.
module tb_my_adder_core;
  import my_adder_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef MY_ADDER_SAT_EN
  localparam logic [31:0] OVF_ADD_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_ADD_EXP = 32'h8000_0000;
`endif

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op_count;
  logic        busy;

  my_adder_if #(.DATA_W(DW)) bus ();

  my_adder_core #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .bus      (bus),
    .op_count (op_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  exp_t        fq[$];
  exp_t        m_s1;
  bit          m_s1v;
  logic [31:0] m_acc;
  logic [31:0] m_cnt;
  bit          m_ready;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain signed/unsigned 64-bit arithmetic.
  function automatic exp_t ref_op(input int op, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] acc);
    exp_t r;
    logic [31:0] x, y;
    longint ux, uy, us, sx, sy, ss;
    r.data = 32'd0; r.carry = 1'b0; r.ovf = 1'b0;
    if (op == 3) begin
      acc = 32'd0;
      return r;
    end
    x  = (op == 2) ? acc : a;
    y  = (op == 2) ? a : b;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = $signed(x);
    sy = $signed(y);
    if (op == 1) begin
      us = ux - uy; ss = sx - sy; r.carry = (ux < uy);
    end else begin
      us = ux + uy; ss = sx + sy; r.carry = (us > 64'sh0000_0000_FFFF_FFFF);
    end
    r.data = us[31:0];
    r.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
`ifdef MY_ADDER_SAT_EN
    if (r.ovf) r.data = (ss > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    if (op == 2) acc = r.data;
    return r;
  endfunction

  task automatic reset_model();
    fq.delete();
    m_s1v = 1'b0; m_acc = 32'd0; m_cnt = 32'd0; m_ready = 1'b0;
  endtask

  task automatic check_outputs();
    chk("cmd_ready", bus.cmd_ready, m_ready);
    chk("res_valid", bus.res_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("res_data", bus.res_data, fq[0].data);
      chk("res_carry", bus.res_carry, fq[0].carry);
      chk("res_ovf", bus.res_ovf, fq[0].ovf);
    end
    chk("op_count", op_count, m_cnt);
    chk("busy", busy, m_s1v || (fq.size() > 0));
  endtask

  // One clock edge: model acceptance/push/pop, then compare all outputs.
  task automatic cycle();
    bit acc_now, pop_now;
    int op;
    logic [31:0] a, b;
    chk("fifo_write_while_full", {63'd0, dut.s1_valid_q & dut.fifo_full_s}, 64'd0);
    acc_now = bus.cmd_valid && m_ready;
    pop_now = bus.res_ready && (fq.size() > 0);
    op = int'(bus.cmd_op); a = bus.cmd_a; b = bus.cmd_b;
    @(posedge clk); #1;
    if (pop_now) void'(fq.pop_front());
    if (m_s1v) fq.push_back(m_s1);
    m_s1v = acc_now;
    if (acc_now) begin
      m_s1 = ref_op(op, a, b, m_acc);
      m_cnt++;
    end
    m_ready = (fq.size() + int'(m_s1v)) < DEPTH;
    check_outputs();
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = op_e'($urandom_range(0, 3));
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
  endtask

  task automatic send(input int op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op_e'(op); bus.cmd_a = a; bus.cmd_b = b;
    for (int i = 0; i < 40 && !done; i++) begin
      done = m_ready;
      cycle();
    end
    chk("send_timeout", done, 1'b1);
    idle();
  endtask

  task automatic expect_head(input string tag, input logic [31:0] d, input logic c, input logic o);
    chk({tag, "_valid"}, bus.res_valid, 1'b1);
    chk({tag, "_data"}, bus.res_data, d);
    chk({tag, "_carry"}, bus.res_carry, c);
    chk({tag, "_ovf"}, bus.res_ovf, o);
  endtask

  // Single command into an empty FIFO: check latency, value, then pop it.
  task automatic single(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic c, input logic o);
    bus.res_ready = 1'b0;
    send(op, a, b);
    chk({tag, "_lat"}, bus.res_valid, 1'b0);
    cycle();
    expect_head(tag, d, c, o);
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt0;
    idle();
    bus.res_ready = 1'b0;
    reset_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_carry", bus.res_carry, 1'b0);
    chk("rst_res_ovf", bus.res_ovf, 1'b0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_busy", busy, 1'b0);
    #1 rst_n = 1'b1;
    cycle();
    chk("ready_after_reset", bus.cmd_ready, 1'b1);

    // Directed arithmetic boundaries
    single("add_1_2", 0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("op_count_1", op_count, 32'd1);
    single("add_carry", 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    single("add_ovf", 0, 32'h7FFF_FFFF, 32'd1, OVF_ADD_EXP, 1'b0, 1'b1);
    single("sub_borrow", 1, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // CLR, ACC 5, ACC 7 back-to-back with no bubbles
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_CLR; bus.cmd_a = $urandom; bus.cmd_b = $urandom;
    cycle();
    chk("chain_clr_lat", bus.res_valid, 1'b0);
    bus.cmd_op = OP_ACC; bus.cmd_a = 32'd5;
    cycle();
    expect_head("chain_0", 32'd0, 1'b0, 1'b0);
    bus.cmd_a = 32'd7;
    cycle();
    expect_head("chain_5", 32'd5, 1'b0, 1'b0);
    idle();
    cycle();
    expect_head("chain_12", 32'd12, 1'b0, 1'b0);
    cycle();
    chk("chain_empty", bus.res_valid, 1'b0);

    // Fill: six ADDs offered with res_ready low, only four fit
    bus.res_ready = 1'b0;
    cnt0 = m_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_a = $urandom; bus.cmd_b = $urandom;
      cycle();
    end
    idle();
    chk("full_accepted", op_count, cnt0 + 32'd4);
    chk("full_ready_low", bus.cmd_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("drain_ready", bus.cmd_ready, 1'b1);
    chk("drain_busy", busy, 1'b0);

    // Randomized traffic with boundary-heavy operands
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_op    = op_e'($urandom_range(0, 3));
      bus.cmd_a     = pick();
      bus.cmd_b     = pick();
      bus.res_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Asynchronous reset with three results buffered
    bus.res_ready = 1'b0;
    send(0, $urandom, $urandom);
    send(0, $urandom, $urandom);
    send(0, $urandom, $urandom);
    cycle();
    chk("prereset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    chk("async_res_valid", bus.res_valid, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_op_count", op_count, 32'd0);
    chk("async_cmd_ready", bus.cmd_ready, 1'b0);
    chk("async_res_data", bus.res_data, 32'd0);
    #2 rst_n = 1'b1;
    cycle();
    single("acc_after_reset", 2, 32'd4, $urandom, 32'd4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
